// File: rtl/uart_tx_arbiter.sv
// Round-robin, per-packet arbiter in front of a single 64-bit packet UART transmitter.
// Launches the transmitter with a one-cycle send_en, then waits for busy to rise and fall (or time out).
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 64,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic                      send_en,
  output logic [DATA_W-1:0]         send_data,
  input  logic                      tx_busy,
  output logic                      timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                send_en_q, send_en_d;
  logic [DATA_W-1:0]   send_data_q, send_data_d;
  logic                timeout_q, timeout_d;

  logic                found;
  logic [IW-1:0]       cand;
  logic [IW-1:0]       sel_idx;
  logic [DATA_W-1:0]   sel_data;

  // First requester at or after ptr+1, wrapping modulo N_REQ.
  always_comb begin
    found   = 1'b0;
    cand    = '0;
    sel_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % N_REQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == IW'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    send_en_d   = 1'b0;
    send_data_d = send_data_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_busy && found) begin
          state_d     = LAUNCH;
          gnt_d       = N_REQ'(1) << sel_idx;
          send_data_d = sel_data;
          idx_d       = sel_idx;
          send_en_d   = 1'b1;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Give up on the edge where the count reaches the limit, so done lands BUSY_TIMEOUT after LAUNCH.
          if (cnt_d == CW'(BUSY_TIMEOUT - 1)) begin
            state_d   = RELEASE;
            done_d    = N_REQ'(1) << idx_q;
            timeout_d = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = RELEASE;
          done_d  = N_REQ'(1) << idx_q;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        ptr_d   = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(N_REQ - 1);
      idx_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      send_en_q   <= 1'b0;
      send_data_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      send_en_q   <= send_en_d;
      send_data_q <= send_data_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign send_en     = send_en_q;
  assign send_data   = send_data_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table for short sequences plus
// transmitter-model sequences for rotation, full packets and timeout.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 64;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     gnt, done;
  logic             send_en;
  logic [W-1:0]     send_data;
  logic             tx_busy;
  logic             timeout_err;

  always #10 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .BUSY_TIMEOUT(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .send_en(send_en), .send_data(send_data),
    .tx_busy(tx_busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic         rst;
    logic [3:0]   req;
    logic         busy;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic         en;
    logic         tmo;
    logic [63:0]  data;
  } vec_t;

  vec_t        tbl[19];
  logic [63:0] dat[4];
  int checks = 0, errors = 0, cyc = 0;
  int m_mode = 0, m_age = -1, oh_bad = 0;
  int g_idx[8];
  logic [63:0] g_dat[8];
  int n_g, n_d, dn_bad, to_cnt;
  int t_l, t_fall, t_done, t_to, en_cnt;
  logic seen_busy;
  logic [3:0] t_dv;
  int exp2[5];
  int exp3[4];

  function automatic vec_t mk(logic r, logic [3:0] rq, logic b, logic [3:0] g,
                              logic [3:0] d, logic e, logic t, logic [63:0] dd);
    vec_t v;
    v.rst = r; v.req = rq; v.busy = b; v.gnt = g; v.done = d; v.en = e; v.tmo = t; v.data = dd;
    return v;
  endfunction

  function automatic int oh2i(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v == (4'b0001 << i)) return i;
    return -1;
  endfunction

  // mode 1: busy rises 2 cycles after send_en and stays 20 cycles; mode 2: busy never rises
  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    if (!$onehot0(gnt)) oh_bad++;
    if (m_mode != 0) begin
      if (send_en) m_age = 0;
      else if (m_age >= 0 && m_age < 1000) m_age++;
      tx_busy = (m_mode == 1) && (m_age >= 2) && (m_age < 22);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    sys_rst = 1'b1;
    req     = '0;
    tx_busy = 1'b0;
    m_age   = -1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic collect(input int n_done, input int budget);
    n_g = 0; n_d = 0; dn_bad = 0; to_cnt = 0;
    for (int k = 0; k < budget && n_d < n_done; k++) begin
      tick();
      if (send_en) begin
        if (n_g < 8) begin
          g_idx[n_g] = oh2i(gnt);
          g_dat[n_g] = send_data;
        end
        n_g++;
      end
      if (done != 0) begin
        if (done !== gnt) dn_bad++;
        n_d++;
      end
      if (timeout_err) to_cnt++;
    end
  endtask

  initial begin
    dat[0] = 64'h0123_4567_89AB_CDEF;
    dat[1] = 64'h1111_2222_3333_4444;
    dat[2] = 64'hDEAD_BEEF_CAFE_F00D;
    dat[3] = 64'h0F1E_2D3C_4B5A_6978;
    req_data = {dat[3], dat[2], dat[1], dat[0]};
    req      = '0;
    tx_busy  = 1'b0;

    // inputs of row i are sampled at one edge; expected outputs are those after that edge
    tbl[0]  = mk(1, 4'h0, 0, 4'h0, 4'h0, 0, 0, 64'h0);
    tbl[1]  = mk(0, 4'h2, 1, 4'h0, 4'h0, 0, 0, 64'h0);
    tbl[2]  = mk(0, 4'h2, 1, 4'h0, 4'h0, 0, 0, 64'h0);
    tbl[3]  = mk(0, 4'h2, 0, 4'h2, 4'h0, 1, 0, dat[1]);
    tbl[4]  = mk(0, 4'h0, 0, 4'h2, 4'h0, 0, 0, dat[1]);
    tbl[5]  = mk(0, 4'h0, 1, 4'h2, 4'h0, 0, 0, dat[1]);
    tbl[6]  = mk(0, 4'h0, 1, 4'h2, 4'h0, 0, 0, dat[1]);
    tbl[7]  = mk(0, 4'h0, 0, 4'h2, 4'h2, 0, 0, dat[1]);
    tbl[8]  = mk(0, 4'hF, 0, 4'h0, 4'h0, 0, 0, dat[1]);
    tbl[9]  = mk(0, 4'hF, 0, 4'h4, 4'h0, 1, 0, dat[2]);
    tbl[10] = mk(0, 4'h0, 1, 4'h4, 4'h0, 0, 0, dat[2]);
    tbl[11] = mk(0, 4'h0, 1, 4'h4, 4'h0, 0, 0, dat[2]);
    tbl[12] = mk(0, 4'h0, 0, 4'h4, 4'h4, 0, 0, dat[2]);
    tbl[13] = mk(0, 4'h1, 0, 4'h0, 4'h0, 0, 0, dat[2]);
    tbl[14] = mk(0, 4'h1, 0, 4'h1, 4'h0, 1, 0, dat[0]);
    tbl[15] = mk(0, 4'h0, 1, 4'h1, 4'h0, 0, 0, dat[0]);
    tbl[16] = mk(0, 4'h0, 1, 4'h1, 4'h0, 0, 0, dat[0]);
    tbl[17] = mk(1, 4'h0, 1, 4'h0, 4'h0, 0, 0, 64'h0);
    tbl[18] = mk(0, 4'h4, 0, 4'h4, 4'h0, 1, 0, dat[2]);

    for (int i = 0; i < 19; i++) begin
      sys_rst = tbl[i].rst;
      req     = tbl[i].req;
      tx_busy = tbl[i].busy;
      tick();
      chk($sformatf("tbl%0d gnt", i),     64'(gnt),         64'(tbl[i].gnt));
      chk($sformatf("tbl%0d done", i),    64'(done),        64'(tbl[i].done));
      chk($sformatf("tbl%0d send_en", i), 64'(send_en),     64'(tbl[i].en));
      chk($sformatf("tbl%0d timeout", i), 64'(timeout_err), 64'(tbl[i].tmo));
      chk($sformatf("tbl%0d data", i),    send_data,        tbl[i].data);
    end

    // single requester, full packet through the transmitter model
    m_mode = 1;
    reset_dut();
    req = 4'b0001;
    tick();
    t_l = cyc;
    chk("t1 gnt", 64'(gnt), 64'h1);
    chk("t1 send_en", 64'(send_en), 64'h1);
    chk("t1 data", send_data, 64'h0123_4567_89AB_CDEF);
    req = 4'b0000;
    seen_busy = 1'b0; t_fall = -1; t_done = -1; t_dv = '0; en_cnt = 0; to_cnt = 0;
    for (int k = 0; k < 60 && t_done < 0; k++) begin
      tick();
      if (tx_busy) seen_busy = 1'b1;
      if (seen_busy && !tx_busy && t_fall < 0) t_fall = cyc;
      if (done != 0 && t_done < 0) begin t_done = cyc; t_dv = done; end
      if (timeout_err) to_cnt++;
      if (send_en) en_cnt++;
    end
    chk("t1 done after busy falls", 64'(t_done - t_fall), 64'd1);
    chk("t1 done value", 64'(t_dv), 64'h1);
    chk("t1 no timeout", 64'(to_cnt), 64'd0);
    chk("t1 single send_en", 64'(en_cnt), 64'd0);

    // everyone requesting continuously
    reset_dut();
    req = 4'b1111;
    collect(5, 300);
    req = '0;
    exp2 = '{0, 1, 2, 3, 0};
    chk("t2 grants", 64'(n_g), 64'd5);
    chk("t2 dones", 64'(n_d), 64'd5);
    chk("t2 done matches gnt", 64'(dn_bad), 64'd0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2 grant%0d idx", k), 64'(g_idx[k]), 64'(exp2[k]));
      chk($sformatf("t2 grant%0d data", k), g_dat[k], dat[exp2[k]]);
    end

    // pointer rotation with two requesters
    reset_dut();
    req = 4'b1010;
    collect(4, 300);
    req = '0;
    exp3 = '{1, 3, 1, 3};
    chk("t3 grants", 64'(n_g), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3 grant%0d idx", k), 64'(g_idx[k]), 64'(exp3[k]));

    // busy never rises
    m_mode = 2;
    reset_dut();
    req = 4'b0100;
    tick();
    t_l = cyc;
    chk("t4 launch", 64'({gnt, send_en}), 64'({4'b0100, 1'b1}));
    req = '0;
    t_to = -1; t_done = -1; t_dv = '0;
    for (int k = 0; k < 40 && t_to < 0; k++) begin
      tick();
      if (done != 0 && t_done < 0) begin t_done = cyc; t_dv = done; end
      if (timeout_err && t_to < 0) t_to = cyc;
    end
    chk("t4 timeout delay", 64'(t_to - t_l), 64'd16);
    chk("t4 done with timeout", 64'(t_done - t_l), 64'd16);
    chk("t4 done value", 64'(t_dv), 64'h4);
    m_mode = 1;
    m_age  = -1;
    req = 4'b1000;
    collect(1, 80);
    req = '0;
    chk("t4 next grants", 64'(n_g), 64'd1);
    chk("t4 next idx", 64'(g_idx[0]), 64'd3);
    chk("t4 next data", g_dat[0], dat[3]);
    chk("t4 next no timeout", 64'(to_cnt), 64'd0);
    chk("t4 next done matches", 64'(dn_bad), 64'd0);

    chk("gnt one-hot", 64'(oh_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
